// File: rtl/dcache_pkg.sv
// Shared types and address-split constants for the direct-mapped L1 data cache.
package dcache_pkg;

    localparam int TAG_W      = 22;
    localparam int INDEX_W    = 5;
    localparam int WORD_SEL_W = 3;
    localparam int BLOCK_BITS = 256;
    localparam int WORD_W     = 32;

    // Byte address = {tag, index, word select, byte offset}
    localparam int WORD_LSB  = 2;
    localparam int INDEX_LSB = WORD_LSB + WORD_SEL_W;
    localparam int TAG_LSB   = INDEX_LSB + INDEX_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        REFILL
    } state_t;

    function automatic logic [31:0] block_addr(input logic [TAG_W-1:0]   tag,
                                               input logic [INDEX_W-1:0] index);
        return {tag, index, {INDEX_LSB{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Line storage: tag/data arrays plus valid/dirty bits; combinational read, single write port.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 256
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [DATA_W-1:0]  rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic               wr_valid,
    input  logic               wr_dirty,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [DATA_W-1:0]  wr_data
);

    logic [DEPTH-1:0]  valid_reg;
    logic [DEPTH-1:0]  dirty_reg;
    logic [TAG_W-1:0]  tag_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    // Only the status bits are cleared; stale tags/data are harmless once invalid.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            valid_reg <= '0;
            dirty_reg <= '0;
        end else if (wr_en) begin
            valid_reg[wr_index] <= wr_valid;
            dirty_reg[wr_index] <= wr_dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_reg[rd_index];
    assign rd_dirty = dirty_reg[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate L1 D-cache controller: hit logic, word merge
// and the writeback/refill FSM driving the block-wide memory port.
module dcache_ctrl #(
    parameter int LINES      = 32,
    parameter int BLOCK_BITS = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           cpu_addr_i,
    input  logic [31:0]           cpu_data_i,
    input  logic                  cpu_MemRead_i,
    input  logic                  cpu_MemWrite_i,
    output logic [31:0]           cpu_data_o,
    output logic                  cpu_stall_o,
    output logic                  mem_enable_o,
    output logic                  mem_write_o,
    output logic [31:0]           mem_addr_o,
    output logic [BLOCK_BITS-1:0] mem_data_o,
    input  logic [BLOCK_BITS-1:0] mem_data_i,
    input  logic                  mem_ack_i
);
    import dcache_pkg::*;

    localparam int WORDS_PER_LINE = BLOCK_BITS / WORD_W;

    state_t                state_reg;
    logic [WORD_SEL_W-1:0] word_sel;
    logic [INDEX_W-1:0]    index;
    logic [TAG_W-1:0]      tag;
    logic                  unused_byte_offset;

    logic                  rd_valid;
    logic                  rd_dirty;
    logic [TAG_W-1:0]      rd_tag;
    logic [BLOCK_BITS-1:0] rd_data;

    logic                  req;
    logic                  hit;
    logic                  write_hit;
    logic                  refill_done;
    logic [BLOCK_BITS-1:0] merged_block;
    logic                  sram_wr_en;
    logic [INDEX_W-1:0]    sram_wr_index;
    logic [TAG_W-1:0]      sram_wr_tag;
    logic [BLOCK_BITS-1:0] sram_wr_data;

    assign word_sel           = cpu_addr_i[WORD_LSB +: WORD_SEL_W];
    assign index              = cpu_addr_i[INDEX_LSB +: INDEX_W];
    assign tag                = cpu_addr_i[TAG_LSB +: TAG_W];
    assign unused_byte_offset = ^cpu_addr_i[WORD_LSB-1:0];

    dcache_sram #(
        .DEPTH  (LINES),
        .DATA_W (BLOCK_BITS)
    ) u_sram (
        .clk      (clk_i),
        .clr_n    (rst_i),
        .rd_index (index),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (sram_wr_en),
        .wr_index (sram_wr_index),
        .wr_valid (1'b1),
        .wr_dirty (!refill_done),
        .wr_tag   (sram_wr_tag),
        .wr_data  (sram_wr_data)
    );

    assign req         = cpu_MemRead_i | cpu_MemWrite_i;
    assign hit         = req && rd_valid && (rd_tag == tag);
    assign cpu_stall_o = req && (!hit || (state_reg != IDLE));
    assign cpu_data_o  = (hit && (state_reg == IDLE)) ? rd_data[WORD_W*word_sel +: WORD_W] : 32'd0;

    for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_merge
        assign merged_block[gi*WORD_W +: WORD_W] =
            (word_sel == WORD_SEL_W'(gi)) ? cpu_data_i : rd_data[gi*WORD_W +: WORD_W];
    end

    // Refill takes its tag/index from the registered request address so it does not
    // depend on the CPU holding its inputs through the ack edge.
    assign write_hit     = (state_reg == IDLE) && hit && cpu_MemWrite_i;
    assign refill_done   = (state_reg == REFILL) && mem_ack_i;
    assign sram_wr_en    = rst_i && (write_hit || refill_done);
    assign sram_wr_index = refill_done ? mem_addr_o[INDEX_LSB +: INDEX_W] : index;
    assign sram_wr_tag   = refill_done ? mem_addr_o[TAG_LSB +: TAG_W] : tag;
    assign sram_wr_data  = refill_done ? mem_data_i : merged_block;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg    <= IDLE;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (req && !hit) begin
                        mem_enable_o <= 1'b1;
                        if (rd_valid && rd_dirty) begin
                            state_reg   <= WRITEBACK;
                            mem_write_o <= 1'b1;
                            mem_addr_o  <= block_addr(rd_tag, index);
                            mem_data_o  <= rd_data;
                        end else begin
                            state_reg   <= REFILL;
                            mem_write_o <= 1'b0;
                            mem_addr_o  <= block_addr(tag, index);
                        end
                    end
                end
                WRITEBACK: begin
                    // Enable stays high; the same request continues as the refill.
                    if (mem_ack_i) begin
                        state_reg   <= REFILL;
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= block_addr(tag, index);
                    end
                end
                REFILL: begin
                    if (mem_ack_i) begin
                        state_reg    <= IDLE;
                        mem_enable_o <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate L1 data cache controller that sits between the pipeline's MEM stage and the off-chip data memory. It is the requesting side of the data-memory interface: it turns CPU load/store requests into 256-bit block read and write transactions. It stalls the pipeline on a miss until the line is resident.

## Interface
Parameters:
- LINES, 32, number of cache lines (index width = log2(LINES)).
- BLOCK_BITS, 256, line size in bits (32 bytes, 8 words).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- cpu_addr_i  in  32  byte address; bits [1:0] are ignored.
- cpu_data_i  in  32  store data.
- cpu_MemRead_i  in  1  load request.
- cpu_MemWrite_i  in  1  store request; has priority if both request inputs are high.
- cpu_data_o  out  32  load data; valid when a read request is high and cpu_stall_o is low.
- cpu_stall_o  out  1  pipeline stall; combinational.
- mem_enable_o  out  1  memory request valid.
- mem_write_o  out  1  1 = block write, 0 = block read.
- mem_addr_o  out  32  block-aligned address; bits [4:0] are 0.
- mem_data_o  out  256  write-back block.
- mem_data_i  in  256  refill block.
- mem_ack_i  in  1  one-cycle completion pulse from memory.

## Operation
- Address fields:
  - word select = [4:2]
  - index = [9:5]
  - tag = [31:10] (22 bits)
- Per line: valid, dirty, tag and a 256-bit data block. Word w occupies bits [32w+31:32w].
- hit = request && valid[index] && tag match.
- Read hit: cpu_data_o = the selected word, combinationally; cpu_stall_o = 0.
- Write hit: at the edge, the selected word is replaced by cpu_data_i and dirty is set. cpu_stall_o = 0.
- No request: no state change; cpu_stall_o = 0; cpu_data_o is don't-care (drives 0).
- Miss (request && !hit): cpu_stall_o = 1 in the same cycle. The CPU holds all cpu_* inputs stable while stalled.
- FSM states:
  - IDLE: on a miss, go to WRITEBACK if the line is valid and dirty, otherwise go to REFILL.
  - WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={old tag, index, 5'b0}, mem_data_o=line data. On mem_ack_i, go to REFILL.
  - REFILL: mem_enable_o=1, mem_write_o=0, mem_addr_o={new tag, index, 5'b0}. On mem_ack_i, at that edge: data=mem_data_i, tag=new tag, valid=1, dirty=0; go to IDLE.
- After refill the held request replays in IDLE as a hit. A store then merges its word and sets dirty.
- Memory handshake rules:
  - mem_enable_o, mem_addr_o, mem_write_o and mem_data_o are registered and stay stable until the edge on which mem_ack_i is sampled.
  - mem_ack_i outside WRITEBACK/REFILL is ignored.
  - mem_enable_o stays high across the WRITEBACK→REFILL transition. Only mem_write_o and mem_addr_o change.
- Reset (rst_i low at an edge), including in the middle of a transaction:
  - state=IDLE; all valid and dirty bits cleared.
  - mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0.
  - Data and tag arrays are not cleared.
  - Any in-flight memory transaction is abandoned; a late ack is ignored.

## Timing
- Hits: zero added latency.
- Memory acks in the Nth cycle of mem_enable_o.
- Clean miss: the miss is detected in cycle 0, REFILL runs in cycles 1..N, and the hit occurs in cycle N+1. Stall lasts N+1 cycles.
- Dirty miss: WRITEBACK runs in cycles 1..N, REFILL in cycles N+1..2N, and the hit occurs in cycle 2N+1. Stall lasts 2N+1 cycles.
- Reset values:
  - cpu_stall_o=0 with no request.
  - cpu_data_o=0.
  - All mem_* outputs 0.

## Structure
- Shared package dcache_pkg holds:
  - the state enum (IDLE, WRITEBACK, REFILL)
  - TAG_W=22, INDEX_W=5, WORD_SEL_W=3, BLOCK_BITS=256
  - field-extract constants for the address split.
- Sub-module dcache_sram holds the tag, valid, dirty and data arrays:
  - one combinational read port
  - one write port with enable
  - a synchronous active-low clear for valid and dirty only.
- The controller FSM, hit logic and word merge live in dcache_ctrl.

## Test plan
Memory model acks on the 10th enable cycle.
- Reset, then read 0x0000_0000 → stall for 11 cycles; one REFILL at address 0x0; cpu_data_o = model word 0 on cycle 11.
- Write 0x0000_0004 = 0xDEADBEEF on the resident line → no stall, no mem_enable_o. A following read returns 0xDEADBEEF.
- Read 0x0000_0400 (same index, new tag), line dirty → WRITEBACK at address 0x0 with mem_data_o word 1 = 0xDEADBEEF. Then REFILL at 0x400. Stall lasts 21 cycles.
- Assert cpu_MemRead_i and cpu_MemWrite_i together on a miss → the store wins; the line ends dirty with the merged word.
- Pull rst_i low in REFILL cycle 5 → next edge: mem_enable_o=0, state IDLE. A later read of the same address misses again. An ack arriving after reset causes no change.
- Sweep 32 indices, writing then re-reading each → no second miss; all data matches.
